sd_spi: RTL and testbench

SPI byte-transfer engine for the SD card interface. It sits directly below the port decoder that handles I/O ports E7/EB. That decoder converts CPU port accesses into single-cycle `tx`/`rx` strobes and drives chip select itself. This block shifts one byte per strobe over a mode-0 SPI link, paced by an external clock enable, and holds the last byte received for the CPU to read.

---
 rtl/sd_spi.sv | 121 ++++++++++++
 tb/tb_sd_spi.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi.sv
`default_nettype none
// ============================================================================
//  Module   : sd_spi
//  Purpose  : SPI mode-0 byte-transfer engine for the SD card port. A single
//             clock strobe (tx or rx) starts one 8-bit exchange. The exchange
//             is paced by ce, where each ce cycle is one SPI half-period. The
//             last fully received byte is held on q.
//  Ports    : clock, reset (async, active high)
//             ce         - half-period enable
//             tx / rx    - start strobes (tx sends d, rx sends FILL)
//             d / q      - transmit byte in / last received byte out
//             busy       - transfer in progress
//             ck, mosi   - SPI clock (idle low) and data out (idle high)
//             miso       - SPI data in
//  Revision : 1.0 - initial release
// ============================================================================
module sd_spi (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       tx,
    input  logic       rx,
    input  logic [7:0] d,
    output logic [7:0] q,
    output logic       busy,
    output logic       ck,
    input  logic       miso,
    output logic       mosi
);

    localparam logic [7:0] FILL = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nx;
    logic [7:0] r_txsr;
    logic [7:0] r_rxsr;
    logic [7:0] r_q;
    logic [3:0] r_cnt;
    logic       r_busy;
    logic       r_ck;
    logic       r_mosi;

    logic       w_start;
    logic [7:0] w_load;
    logic       w_last;

    // tx has priority over rx when both strobes coincide.
    assign w_start = tx | rx;
    assign w_load  = tx ? d : FILL;
    assign w_last  = ce && (r_cnt == 4'd15);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_nx = ST_SHIFT;
            ST_SHIFT: if (w_last)  w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_txsr <= 8'hFF;
            r_rxsr <= 8'hFF;
            r_q    <= 8'hFF;
            r_cnt  <= 4'd0;
            r_busy <= 1'b0;
            r_ck   <= 1'b0;
            r_mosi <= 1'b1;
        end else if (r_state == ST_IDLE) begin
            // ce is ignored here, so a ce coinciding with the strobe never
            // counts as a half-period of the new transfer.
            if (w_start) begin
                r_txsr <= w_load;
                r_cnt  <= 4'd0;
                r_busy <= 1'b1;
                r_mosi <= w_load[7];
            end
        end else if (ce) begin
            // Counter stops at 15; the transfer ends there, so no wrap.
            if (r_cnt != 4'd15) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (!r_cnt[0]) begin
                // Rising ck: sample the card while mosi is held stable.
                r_ck   <= 1'b1;
                r_rxsr <= {r_rxsr[6:0], miso};
            end else if (r_cnt != 4'd15) begin
                // Falling ck: present the next bit, MSB first.
                r_ck   <= 1'b0;
                r_txsr <= {r_txsr[6:0], 1'b0};
                r_mosi <= r_txsr[6];
            end else begin
                r_ck   <= 1'b0;
                r_q    <= r_rxsr;
                r_mosi <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign q    = r_q;
    assign busy = r_busy;
    assign ck   = r_ck;
    assign mosi = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_spi
//  Purpose  : Self-checking bench for sd_spi. A transfer-level model predicts
//             the byte seen on mosi, the byte landing on q, the ck pulse count
//             and the ce count of every exchange; a card model or a loopback
//             drives miso.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sd_spi;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ce    = 1'b0;
    logic       tx    = 1'b0;
    logic       rx    = 1'b0;
    logic [7:0] d     = 8'h00;
    logic [7:0] q;
    logic       busy;
    logic       ck;
    logic       miso;
    logic       mosi;

    int         errors = 0;
    int         checks = 0;

    // Monitors.
    int         rise_cnt = 0;
    int         ce_cnt   = 0;
    logic [7:0] cap      = 8'hFF;
    logic       ck_prev  = 1'b0;

    // Card model / stimulus control.
    int         card_base = 0;
    logic [7:0] card_byte = 8'hFF;
    logic       loop      = 1'b1;
    int         ce_mode   = 0;
    int         card_idx;
    logic       card_bit;
    logic [7:0] exp_q     = 8'hFF;

    sd_spi u_dut (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .tx    (tx),
        .rx    (rx),
        .d     (d),
        .q     (q),
        .busy  (busy),
        .ck    (ck),
        .miso  (miso),
        .mosi  (mosi)
    );

    always #5 clock = ~clock;

    // ce pattern: 0 off, 1 every other clock, 2 continuous, 3 random.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ce_mode)
                0:       ce = 1'b0;
                1:       ce = ~ce;
                2:       ce = 1'b1;
                default: ce = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Observe ck rising edges and the mosi bit that is present at each one.
    always @(negedge clock) begin
        if (ck && !ck_prev) begin
            rise_cnt = rise_cnt + 1;
            cap      = {cap[6:0], mosi};
        end
        ck_prev = ck;
    end

    // Half-periods consumed: ce cycles seen while a transfer was running.
    always @(posedge clock) begin
        if (busy && ce) ce_cnt = ce_cnt + 1;
    end

    // Card returns card_byte MSB first, advancing one bit per ck rise.
    always_comb begin
        card_idx = rise_cnt - card_base;
        card_bit = 1'b1;
        if (card_idx >= 0 && card_idx < 8) card_bit = card_byte[7 - card_idx];
    end

    assign miso = loop ? mosi : card_bit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer. intrude_at: ck-rise count at which a stray tx is issued
    // (-1 none). abort_at: ck-rise count at which reset is pulsed (-1 none).
    task automatic xfer(input string tag, input logic do_tx, input logic do_rx,
                        input logic [7:0] db, input logic [7:0] card,
                        input logic lp, input logic immediate,
                        input int intrude_at, input int abort_at);
        logic [7:0] exp_tx;
        logic [7:0] exp_rx;
        int         r0;
        int         c0;
        int         n;
        logic       q_moved;
        logic       intruded;
        logic       aborted;
        exp_tx = do_tx ? db : 8'hFF;
        exp_rx = lp ? exp_tx : card;
        if (!immediate) begin
            @(posedge clock);
            #1;
        end
        loop      = lp;
        card_byte = card;
        card_base = rise_cnt;
        r0        = rise_cnt;
        c0        = ce_cnt;
        tx = do_tx;
        rx = do_rx;
        d  = db;
        @(posedge clock);
        #1;
        tx = 1'b0;
        rx = 1'b0;
        d  = 8'($urandom);
        check({tag, " busy at t+1"}, 32'(busy), 32'd1);
        check({tag, " first mosi"}, 32'(mosi), 32'(exp_tx[7]));
        q_moved  = 1'b0;
        intruded = 1'b0;
        aborted  = 1'b0;
        n        = 0;
        while (busy && n < 400 && !aborted) begin
            @(negedge clock);
            tx = 1'b0;
            if (busy && q !== exp_q) q_moved = 1'b1;
            if (!intruded && intrude_at >= 0 && (rise_cnt - r0) == intrude_at) begin
                tx       = 1'b1;
                d        = 8'hFF;
                intruded = 1'b1;
            end
            if (abort_at >= 0 && (rise_cnt - r0) == abort_at) begin
                reset = 1'b1;
                #1;
                check({tag, " abort ck"}, 32'(ck), 32'd0);
                check({tag, " abort mosi"}, 32'(mosi), 32'd1);
                check({tag, " abort busy"}, 32'(busy), 32'd0);
                check({tag, " abort q"}, 32'(q), 32'hFF);
                #2;
                reset   = 1'b0;
                exp_q   = 8'hFF;
                aborted = 1'b1;
            end
            n++;
        end
        tx = 1'b0;
        if (!aborted) begin
            check({tag, " done in time"}, 32'(busy), 32'd0);
            check({tag, " q held"}, 32'(q_moved), 32'd0);
            check({tag, " ck pulses"}, 32'(rise_cnt - r0), 32'd8);
            check({tag, " ce count"}, 32'(ce_cnt - c0), 32'd16);
            check({tag, " mosi byte"}, 32'(cap), 32'(exp_tx));
            exp_q = exp_rx;
            check({tag, " q"}, 32'(q), 32'(exp_q));
            check({tag, " idle mosi"}, 32'(mosi), 32'd1);
            check({tag, " idle ck"}, 32'(ck), 32'd0);
        end
    endtask

    initial begin
        int         r0;
        logic       t_tx;
        logic       t_rx;
        logic [7:0] t_d;
        logic [7:0] t_card;
        logic       t_lp;

        // Reset, then idle with ce toggling: nothing may move.
        ce_mode = 1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        r0 = rise_cnt;
        repeat (100) @(posedge clock);
        @(negedge clock);
        check("reset ck pulses", 32'(rise_cnt - r0), 32'd0);
        check("reset ck", 32'(ck), 32'd0);
        check("reset mosi", 32'(mosi), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset q", 32'(q), 32'hFF);

        // rx with a card returning 3C; q stays FF meanwhile.
        xfer("rx3C", 1'b0, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b0, -1, -1);

        // tx A5 in loopback.
        xfer("txA5", 1'b1, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, -1, -1);

        // tx and rx together with d=00; stray tx at cnt=7 ignored.
        ce_mode = 2;
        xfer("txrx", 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 4, -1);

        // Reset at cnt=9 while receiving 81, then a clean tx 55.
        ce_mode = 1;
        xfer("abort", 1'b0, 1'b1, 8'h00, 8'h81, 1'b0, 1'b0, -1, 5);
        xfer("post", 1'b1, 1'b0, 8'h55, 8'h00, 1'b1, 1'b0, -1, -1);

        // Back-to-back with echoing card.
        ce_mode = 2;
        xfer("b2b1", 1'b1, 1'b0, 8'h12, 8'h00, 1'b1, 1'b0, -1, -1);
        xfer("b2b2", 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, -1, -1);

        // Randomized transfers with random ce pacing.
        ce_mode = 3;
        for (int i = 0; i < 8; i++) begin
            t_tx   = 1'($urandom_range(0, 1));
            t_rx   = t_tx ? 1'($urandom_range(0, 1)) : 1'b1;
            t_d    = 8'($urandom);
            t_card = 8'($urandom);
            t_lp   = 1'($urandom_range(0, 1));
            xfer("rand", t_tx, t_rx, t_d, t_card, t_lp, 1'($urandom_range(0, 1)), -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
